pwm_seno_multi: RTL and testbench
=================================

Name: pwm_seno_multi

Overview:
Multi-channel sine-modulated PWM generator, the parametrised successor of the single-channel sine PWM block. A shared R-bit period counter drives CH channels. Each channel reads a 2^L-entry sine table at a common phase index plus a per-channel offset, or runs in fixed-duty, off or on mode. A valid/ready config port double-buffers all settings; new settings take effect only at a period boundary, so outputs never glitch. The block sits between the control/UART logic and the output pins (LED, motor or audio filter).

Parameters:
- R, 8: period counter width; PWM period = 2^R clk cycles.
- CH, 3: number of PWM channels.
- L, 5: sine table address width; table depth = 2^L.
- DW, 16: width of the periods-per-step divider.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  config word present.
- cfg_ready  out  1  shadow register free; the handshake completes on cfg_valid & cfg_ready.
- cfg_div  in  DW  PWM periods per sine step; 0 is treated as 1.
- cfg_mode  in  2*CH  per channel: 00 off, 01 sine, 10 fixed, 11 on; channel i uses bits [2i+1:2i].
- cfg_offset  in  L*CH  per-channel phase offset; channel i uses bits [L*i+L-1:L*i].
- cfg_duty  in  R  duty value for fixed mode, shared by all channels.
- pwm_out  out  CH  registered PWM outputs.
- period_tick  out  1  one-cycle pulse, high in the cycle where the counter equals 0.
- phase_idx  out  L  current common phase index.

Behaviour:
- Reset (async, while high): cnt=0, prescale=0, phase=0, duty_q[i]=0, pwm_out=0, period_tick=0, pending=0, cfg_ready=1.
- Active config after reset: div=1, all modes=01, all offsets=0, duty=2^(R-1).
- cnt increments every clk and wraps from 2^R-1 to 0. Define pend = (cnt==2^R-1).
- period_tick is registered from pend, so it is high when cnt==0.
- On each edge where pend is true:
  - If prescale==div_active-1: prescale<=0 and phase<=phase+1 (mod 2^L, wrapping 2^L-1 to 0).
  - Otherwise prescale<=prescale+1.
  - duty_q[i] is loaded from phase_next, meaning the phase value being written on that same edge.
- duty_q[i] per mode:
  - Sine: LUT[(phase_next+off_i) mod 2^L].
  - Fixed: duty_active.
  - Off: 0.
  - On: forces pwm_out[i]=1, regardless of duty_q.
- LUT[k] = round(2^(R-1) + 2^(R-1)*sin(2πk/2^L)), clamped to [0, 2^R-1]. Reference values for R=8, L=5: LUT[0]=128, LUT[1]=153, LUT[8]=255, LUT[16]=128, LUT[24]=0.
- pwm_out[i] <= (cnt < duty_q[i]) | on_i.
  - One clk of latency relative to cnt.
  - High for exactly duty_q clocks per period.
  - duty_q never changes mid-period.
- Config handshake:
  - cfg_ready = ~pending.
  - On a handshake, the shadow captures all cfg_* fields and pending<=1.
  - At the next pend edge that occurs strictly after the handshake edge: active<=shadow, pending<=0, prescale<=0, phase<=0. duty_q on that edge is computed from the new config with phase_next=0.
  - A handshake on the same edge as pend does not apply on that edge; it applies one period later.
  - cfg_valid while cfg_ready=0 is ignored. The source must hold cfg_valid.
- Reset mid-operation drops any pending shadow, restores the default active config, and forces outputs low immediately.
- All arithmetic on indices is unsigned and mod 2^L. No combinational path exists from cfg_* to pwm_out.

Decomposition:
- Package pwm_pkg holds:
  - Mode localparams: MODE_OFF, MODE_SINE, MODE_FIXED, MODE_ON.
  - A constant function sine_value(k, R, L) that builds the table at elaboration.
- Sub-module pwm_seno_lut (combinational ROM with parameters R and L, address in, duty out), instantiated once per channel.
- Period counter, prescaler, phase and config shadow live in the top block and are shared by all channels.

Test Plan:
- Default after reset (R=8, L=5, CH=3):
  - pwm_out=000 for the first 257 clk.
  - The second period shows each channel high for 153 clk (LUT[1]).
  - phase_idx=1, and period_tick pulses every 256 clk.
- Fixed mode: config mode ch0=10, duty=64 -> after the boundary following the handshake, ch0 is high 64 clk per 256. Off and on modes give constant 0 and 1.
- Offsets 0/8/16, div=1 -> on the apply edge phase=0, so in that period ch0 is high 128 clk, ch1 255, ch2 128.
- cfg_div=4 -> phase_idx advances every 4 periods and wraps 31->0 after 128 periods. cfg_div=0 behaves exactly like 1.
- Back-to-back configs:
  - The second cfg_valid sees cfg_ready=0 until the apply edge and is accepted one cycle later.
  - A handshake coinciding with pend applies a full period later.
- Async reset asserted at cnt=100 with a config pending -> pwm_out=0 within the same cycle. After release, the default config is active and cfg_ready=1.

Source files
------------

// File: rtl/pwm_seno_multi_pkg.sv
// Shared constants for the multi-channel sine PWM generator.
// Mode encodings and the elaboration-time sine table builder.
package pwm_pkg;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_SINE  = 2'b01;
    localparam logic [1:0] MODE_FIXED = 2'b10;
    localparam logic [1:0] MODE_ON    = 2'b11;

    // Sine via Taylor series on an angle folded into [-pi, pi]; only
    // evaluated with constant arguments while building the ROM.
    function automatic int sine_value(input int k, input int r, input int l);
        real pi;
        real x;
        real term;
        real s;
        real half;
        real v;
        int  res;
        pi   = 3.14159265358979323846;
        x    = 2.0 * pi * real'(k) / real'(1 << l);
        if (x > pi) begin
            x = x - 2.0 * pi;
        end
        term = x;
        s    = x;
        for (int n = 1; n < 14; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        half = real'(1 << (r - 1));
        v    = half + half * s + 0.5;
        if (v < 0.0) begin
            v = 0.0;
        end
        res = $rtoi(v);
        if (res > (1 << r) - 1) begin
            res = (1 << r) - 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_seno_lut.sv
// Combinational sine ROM: 2^L entries of R-bit duty values.
// Contents are fixed at elaboration from pwm_pkg::sine_value.
module pwm_seno_lut
    import pwm_pkg::*;
#(
    parameter int R = 8,
    parameter int L = 5
) (
    input  logic [L-1:0] addr,
    output logic [R-1:0] duty
);

    logic [R-1:0] rom [2**L];

    for (genvar k = 0; k < 2**L; k++) begin : g_rom
        localparam int V = sine_value(k, R, L);
        assign rom[k] = V[R-1:0];
    end

    assign duty = rom[addr];

endmodule

// File: rtl/pwm_seno_multi.sv
// Multi-channel sine-modulated PWM with a double-buffered config port.
// Settings and duty values only change at period boundaries.
module pwm_seno_multi
    import pwm_pkg::*;
#(
    parameter int R  = 8,
    parameter int CH = 3,
    parameter int L  = 5,
    parameter int DW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DW-1:0]     cfg_div,
    input  logic [2*CH-1:0]   cfg_mode,
    input  logic [L*CH-1:0]   cfg_offset,
    input  logic [R-1:0]      cfg_duty,
    output logic [CH-1:0]     pwm_out,
    output logic              period_tick,
    output logic [L-1:0]      phase_idx
);

    localparam logic [DW-1:0]   DIV_DEF  = DW'(1);
    localparam logic [2*CH-1:0] MODE_DEF = {CH{MODE_SINE}};
    localparam logic [R-1:0]    DUTY_DEF = {1'b1, {(R-1){1'b0}}};

    logic [R-1:0]    cnt;
    logic [DW-1:0]   prescale;
    logic [L-1:0]    phase;
    logic [L-1:0]    phase_next;
    logic            pending;
    logic            pend;
    logic            apply;
    logic            handshake;
    logic            step;

    logic [DW-1:0]   div_act;
    logic [DW-1:0]   div_sh;
    logic [DW-1:0]   div_eff;
    logic [2*CH-1:0] mode_act;
    logic [2*CH-1:0] mode_sh;
    logic [2*CH-1:0] mode_sel;
    logic [L*CH-1:0] off_act;
    logic [L*CH-1:0] off_sh;
    logic [L*CH-1:0] off_sel;
    logic [R-1:0]    duty_act;
    logic [R-1:0]    duty_sh;
    logic [R-1:0]    duty_sel;

    assign pend      = (cnt == '1);
    assign handshake = cfg_valid & ~pending;
    assign apply     = pend & pending;
    assign cfg_ready = ~pending;
    assign phase_idx = phase;

    assign div_eff = (div_act == '0) ? DIV_DEF : div_act;
    assign step    = (prescale == div_eff - DIV_DEF);

    // On the apply edge the new settings feed the duty computation directly.
    assign mode_sel = apply ? mode_sh : mode_act;
    assign off_sel  = apply ? off_sh  : off_act;
    assign duty_sel = apply ? duty_sh : duty_act;

    always_comb begin
        phase_next = phase;
        if (apply) begin
            phase_next = '0;
        end else if (step) begin
            phase_next = phase + L'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            prescale    <= '0;
            phase       <= '0;
            period_tick <= 1'b0;
        end else begin
            cnt         <= cnt + R'(1);
            period_tick <= pend;
            if (pend) begin
                phase <= phase_next;
                if (apply || step) begin
                    prescale <= '0;
                end else begin
                    prescale <= prescale + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= 1'b0;
            div_act  <= DIV_DEF;
            mode_act <= MODE_DEF;
            off_act  <= '0;
            duty_act <= DUTY_DEF;
            div_sh   <= '0;
            mode_sh  <= '0;
            off_sh   <= '0;
            duty_sh  <= '0;
        end else if (handshake) begin
            div_sh   <= cfg_div;
            mode_sh  <= cfg_mode;
            off_sh   <= cfg_offset;
            duty_sh  <= cfg_duty;
            pending  <= 1'b1;
        end else if (apply) begin
            div_act  <= div_sh;
            mode_act <= mode_sh;
            off_act  <= off_sh;
            duty_act <= duty_sh;
            pending  <= 1'b0;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [1:0]   md;
        logic [L-1:0] addr;
        logic [R-1:0] sine;
        logic [R-1:0] duty_nx;
        logic [R-1:0] duty_q;
        logic         on;
        logic         pwm_q;

        assign md   = mode_sel[2*i +: 2];
        assign addr = phase_next + off_sel[L*i +: L];
        assign on   = (mode_act[2*i +: 2] == MODE_ON);

        pwm_seno_lut #(
            .R(R),
            .L(L)
        ) u_lut (
            .addr(addr),
            .duty(sine)
        );

        always_comb begin
            duty_nx = '0;
            unique case (md)
                MODE_SINE:  duty_nx = sine;
                MODE_FIXED: duty_nx = duty_sel;
                default:    duty_nx = '0;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                duty_q <= '0;
                pwm_q  <= 1'b0;
            end else begin
                if (pend) begin
                    duty_q <= duty_nx;
                end
                pwm_q <= (cnt < duty_q) | on;
            end
        end

        assign pwm_out[i] = pwm_q;
    end

endmodule

// File: tb/tb_pwm_seno_multi.sv
// Bench for pwm_seno_multi: period-level reference model with
// randomized and directed configurations.
module tb_pwm_seno_multi;

    localparam int R  = 8;
    localparam int CH = 3;
    localparam int L  = 5;
    localparam int DW = 16;
    localparam int P  = 256;
    localparam int N  = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [DW-1:0]     cfg_div = '0;
    logic [2*CH-1:0]   cfg_mode = '0;
    logic [L*CH-1:0]   cfg_offset = '0;
    logic [R-1:0]      cfg_duty = '0;
    logic [CH-1:0]     pwm_out;
    logic              period_tick;
    logic [L-1:0]      phase_idx;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pwm_seno_multi #(
        .R(R),
        .CH(CH),
        .L(L),
        .DW(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_div(cfg_div),
        .cfg_mode(cfg_mode),
        .cfg_offset(cfg_offset),
        .cfg_duty(cfg_duty),
        .pwm_out(pwm_out),
        .period_tick(period_tick),
        .phase_idx(phase_idx)
    );

    // Reference sine table from the closed-form definition.
    int lut [N];

    // Reference model: each period has one duty per channel, derived from
    // the period number since the last config change.
    int k = 0;
    int hs_count = 0;
    bit m_pending;
    int act_div, act_duty, sh_div, sh_duty, base_p;
    int act_mode [CH];
    int act_off [CH];
    int sh_mode [CH];
    int sh_off [CH];
    int dq [CH];
    bit on_q [CH];
    logic [CH-1:0] exp_pwm;
    logic          exp_tick;
    logic          exp_ready;
    logic [L-1:0]  exp_phase;

    always @(posedge clk) begin : model
        int c, q, ph, d;
        bit pb;
        if (reset) begin
            k = 0;
            m_pending = 0;
            act_div = 1;
            act_duty = 128;
            base_p = 0;
            for (int i = 0; i < CH; i++) begin
                act_mode[i] = 1;
                act_off[i] = 0;
                dq[i] = 0;
                on_q[i] = 0;
            end
            exp_pwm = '0;
            exp_tick = 0;
            exp_phase = '0;
            exp_ready = 1;
        end else begin
            c = k % P;
            for (int i = 0; i < CH; i++) begin
                exp_pwm[i] = (c < dq[i]) || on_q[i];
            end
            exp_tick = (c == P - 1);
            pb = m_pending;
            if (cfg_valid && !pb) begin
                sh_div = int'(cfg_div);
                sh_duty = int'(cfg_duty);
                for (int i = 0; i < CH; i++) begin
                    sh_mode[i] = int'(cfg_mode[2*i +: 2]);
                    sh_off[i] = int'(cfg_offset[L*i +: L]);
                end
                m_pending = 1;
                hs_count++;
            end
            if (c == P - 1) begin
                q = k / P + 1;
                if (pb) begin
                    act_div = sh_div;
                    act_duty = sh_duty;
                    act_mode = sh_mode;
                    act_off = sh_off;
                    base_p = q;
                    m_pending = 0;
                end
                d = (act_div == 0) ? 1 : act_div;
                ph = ((q - base_p) / d) % N;
                for (int i = 0; i < CH; i++) begin
                    case (act_mode[i])
                        1: dq[i] = lut[(ph + act_off[i]) % N];
                        2: dq[i] = act_duty;
                        default: dq[i] = 0;
                    endcase
                    on_q[i] = (act_mode[i] == 3);
                end
                exp_phase = ph[L-1:0];
            end
            k++;
            exp_ready = !m_pending;
        end
    end

    task automatic send_cfg(input logic [DW-1:0] div, input logic [2*CH-1:0] mode,
                            input logic [L*CH-1:0] off, input logic [R-1:0] duty);
        int h0;
        bit got;
        @(negedge clk);
        cfg_div = div;
        cfg_mode = mode;
        cfg_offset = off;
        cfg_duty = duty;
        h0 = hs_count;
        cfg_valid = 1;
        got = 0;
        for (int t = 0; t < 2000 && !got; t++) begin
            @(negedge clk);
            if (hs_count != h0) got = 1;
        end
        cfg_valid = 0;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL cfg_accept got no handshake want handshake within 2000 cycles");
        end
    endtask

    task automatic test_reset();
        #1;
        vectors += 4;
        if (pwm_out !== '0) begin
            miscompares++;
            $display("FAIL reset_pwm got %b want 000", pwm_out);
        end
        if (period_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tick got %b want 0", period_tick);
        end
        if (phase_idx !== '0) begin
            miscompares++;
            $display("FAIL reset_phase got %0d want 0", phase_idx);
        end
        if (cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got %b want 1", cfg_ready);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_default();
        int hi [CH];
        int ticks;
        ticks = 0;
        for (int i = 0; i < CH; i++) hi[i] = 0;
        for (int t = 0; t < 3 * P; t++) begin
            @(negedge clk);
            vectors++;
            if ({pwm_out, period_tick, phase_idx, cfg_ready} !==
                {exp_pwm, exp_tick, exp_phase, exp_ready}) begin
                miscompares++;
                $display("FAIL default k=%0d got pwm=%b tick=%b ph=%0d rdy=%b want pwm=%b tick=%b ph=%0d rdy=%b",
                         k, pwm_out, period_tick, phase_idx, cfg_ready, exp_pwm, exp_tick, exp_phase, exp_ready);
            end
            if (k > P && k <= 2 * P) begin
                for (int i = 0; i < CH; i++) if (pwm_out[i]) hi[i]++;
            end
            if (period_tick) ticks++;
        end
        for (int i = 0; i < CH; i++) begin
            vectors++;
            if (hi[i] != lut[1]) begin
                miscompares++;
                $display("FAIL default_high ch%0d got %0d want %0d", i, hi[i], lut[1]);
            end
        end
        vectors++;
        if (ticks != 3) begin
            miscompares++;
            $display("FAIL default_ticks got %0d want 3", ticks);
        end
    endtask

    task automatic test_fixed();
        send_cfg(16'd1, 6'b11_00_10, '0, 8'd64);
        for (int t = 0; t < 3 * P; t++) begin
            @(negedge clk);
            vectors++;
            if ({pwm_out, period_tick, phase_idx, cfg_ready} !==
                {exp_pwm, exp_tick, exp_phase, exp_ready}) begin
                miscompares++;
                $display("FAIL fixed k=%0d got pwm=%b tick=%b ph=%0d rdy=%b want pwm=%b tick=%b ph=%0d rdy=%b",
                         k, pwm_out, period_tick, phase_idx, cfg_ready, exp_pwm, exp_tick, exp_phase, exp_ready);
            end
        end
    endtask

    task automatic test_offsets();
        send_cfg(16'd1, 6'b01_01_01, {5'd16, 5'd8, 5'd0}, 8'd0);
        for (int t = 0; t < 3 * P; t++) begin
            @(negedge clk);
            vectors++;
            if ({pwm_out, period_tick, phase_idx, cfg_ready} !==
                {exp_pwm, exp_tick, exp_phase, exp_ready}) begin
                miscompares++;
                $display("FAIL offsets k=%0d got pwm=%b tick=%b ph=%0d rdy=%b want pwm=%b tick=%b ph=%0d rdy=%b",
                         k, pwm_out, period_tick, phase_idx, cfg_ready, exp_pwm, exp_tick, exp_phase, exp_ready);
            end
        end
    endtask

    task automatic test_div();
        send_cfg(16'd4, 6'b01_01_01, {5'd31, 5'd5, 5'd0}, 8'd0);
        for (int t = 0; t < 132 * P; t++) begin
            @(negedge clk);
            vectors++;
            if ({pwm_out, period_tick, phase_idx, cfg_ready} !==
                {exp_pwm, exp_tick, exp_phase, exp_ready}) begin
                miscompares++;
                $display("FAIL div4 k=%0d got pwm=%b tick=%b ph=%0d rdy=%b want pwm=%b tick=%b ph=%0d rdy=%b",
                         k, pwm_out, period_tick, phase_idx, cfg_ready, exp_pwm, exp_tick, exp_phase, exp_ready);
            end
        end
        send_cfg(16'd0, 6'b01_01_01, {5'd3, 5'd2, 5'd1}, 8'd0);
        for (int t = 0; t < 6 * P; t++) begin
            @(negedge clk);
            vectors++;
            if ({pwm_out, period_tick, phase_idx, cfg_ready} !==
                {exp_pwm, exp_tick, exp_phase, exp_ready}) begin
                miscompares++;
                $display("FAIL div0 k=%0d got pwm=%b tick=%b ph=%0d rdy=%b want pwm=%b tick=%b ph=%0d rdy=%b",
                         k, pwm_out, period_tick, phase_idx, cfg_ready, exp_pwm, exp_tick, exp_phase, exp_ready);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            send_cfg(DW'($urandom_range(0, 3)), (2*CH)'($urandom_range(0, 63)),
                     (L*CH)'($urandom), R'($urandom));
            for (int t = 0; t < 3 * P; t++) begin
                @(negedge clk);
                vectors++;
                if ({pwm_out, period_tick, phase_idx, cfg_ready} !==
                    {exp_pwm, exp_tick, exp_phase, exp_ready}) begin
                    miscompares++;
                    $display("FAIL random%0d k=%0d got pwm=%b tick=%b ph=%0d rdy=%b want pwm=%b tick=%b ph=%0d rdy=%b",
                             n, k, pwm_out, period_tick, phase_idx, cfg_ready, exp_pwm, exp_tick, exp_phase, exp_ready);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int h0;
        bit got;
        send_cfg(16'd1, 6'b10_10_10, '0, 8'd200);
        cfg_mode = 6'b01_10_11;
        cfg_offset = {5'd4, 5'd0, 5'd0};
        cfg_duty = 8'd17;
        cfg_div = 16'd2;
        h0 = hs_count;
        cfg_valid = 1;
        got = 0;
        for (int t = 0; t < 600 && !got; t++) begin
            @(negedge clk);
            vectors++;
            if ({pwm_out, period_tick, phase_idx, cfg_ready} !==
                {exp_pwm, exp_tick, exp_phase, exp_ready}) begin
                miscompares++;
                $display("FAIL b2b_wait k=%0d got pwm=%b tick=%b ph=%0d rdy=%b want pwm=%b tick=%b ph=%0d rdy=%b",
                         k, pwm_out, period_tick, phase_idx, cfg_ready, exp_pwm, exp_tick, exp_phase, exp_ready);
            end
            if (hs_count != h0) got = 1;
        end
        cfg_valid = 0;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL b2b_accept got no handshake want handshake within 600 cycles");
        end
        for (int t = 0; t < 2 * P; t++) begin
            @(negedge clk);
            vectors++;
            if ({pwm_out, period_tick, phase_idx, cfg_ready} !==
                {exp_pwm, exp_tick, exp_phase, exp_ready}) begin
                miscompares++;
                $display("FAIL b2b k=%0d got pwm=%b tick=%b ph=%0d rdy=%b want pwm=%b tick=%b ph=%0d rdy=%b",
                         k, pwm_out, period_tick, phase_idx, cfg_ready, exp_pwm, exp_tick, exp_phase, exp_ready);
            end
        end
        // Present a config exactly on the period-boundary edge.
        got = 0;
        for (int t = 0; t < 1000 && !got; t++) begin
            @(negedge clk);
            if (k % P == P - 1 && !m_pending) got = 1;
        end
        cfg_mode = 6'b10_01_10;
        cfg_duty = 8'd99;
        cfg_div = 16'd1;
        h0 = hs_count;
        cfg_valid = 1;
        @(negedge clk);
        cfg_valid = 0;
        vectors++;
        if (hs_count != h0 + 1 || !got) begin
            miscompares++;
            $display("FAIL pend_handshake got hs=%0d want hs=%0d", hs_count - h0, 1);
        end
        for (int t = 0; t < 2 * P + 8; t++) begin
            @(negedge clk);
            vectors++;
            if ({pwm_out, period_tick, phase_idx, cfg_ready} !==
                {exp_pwm, exp_tick, exp_phase, exp_ready}) begin
                miscompares++;
                $display("FAIL pend_apply k=%0d got pwm=%b tick=%b ph=%0d rdy=%b want pwm=%b tick=%b ph=%0d rdy=%b",
                         k, pwm_out, period_tick, phase_idx, cfg_ready, exp_pwm, exp_tick, exp_phase, exp_ready);
            end
        end
    endtask

    task automatic test_async_reset();
        bit got;
        send_cfg(16'd1, 6'b11_11_11, '0, 8'd0);
        for (int t = 0; t < 2 * P; t++) begin
            @(negedge clk);
            vectors++;
            if ({pwm_out, period_tick, phase_idx, cfg_ready} !==
                {exp_pwm, exp_tick, exp_phase, exp_ready}) begin
                miscompares++;
                $display("FAIL on_mode k=%0d got pwm=%b tick=%b ph=%0d rdy=%b want pwm=%b tick=%b ph=%0d rdy=%b",
                         k, pwm_out, period_tick, phase_idx, cfg_ready, exp_pwm, exp_tick, exp_phase, exp_ready);
            end
        end
        got = 0;
        for (int t = 0; t < 600 && !got; t++) begin
            @(negedge clk);
            if (k % P == 10) got = 1;
        end
        send_cfg(16'd1, 6'b10_10_10, '0, 8'd50);
        got = 0;
        for (int t = 0; t < 600 && !got; t++) begin
            @(negedge clk);
            vectors++;
            if ({pwm_out, period_tick, phase_idx, cfg_ready} !==
                {exp_pwm, exp_tick, exp_phase, exp_ready}) begin
                miscompares++;
                $display("FAIL pre_reset k=%0d got pwm=%b tick=%b ph=%0d rdy=%b want pwm=%b tick=%b ph=%0d rdy=%b",
                         k, pwm_out, period_tick, phase_idx, cfg_ready, exp_pwm, exp_tick, exp_phase, exp_ready);
            end
            if (k % P == 100) got = 1;
        end
        #1 reset = 1;
        #1;
        vectors += 4;
        if (pwm_out !== '0) begin
            miscompares++;
            $display("FAIL async_pwm got %b want 000", pwm_out);
        end
        if (cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_ready got %b want 1", cfg_ready);
        end
        if (phase_idx !== '0) begin
            miscompares++;
            $display("FAIL async_phase got %0d want 0", phase_idx);
        end
        if (!got || m_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL async_setup got pending=%b reached=%b want 1 1", m_pending, got);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        for (int t = 0; t < 2 * P + 4; t++) begin
            @(negedge clk);
            vectors++;
            if ({pwm_out, period_tick, phase_idx, cfg_ready} !==
                {exp_pwm, exp_tick, exp_phase, exp_ready}) begin
                miscompares++;
                $display("FAIL post_reset k=%0d got pwm=%b tick=%b ph=%0d rdy=%b want pwm=%b tick=%b ph=%0d rdy=%b",
                         k, pwm_out, period_tick, phase_idx, cfg_ready, exp_pwm, exp_tick, exp_phase, exp_ready);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            real v;
            int r;
            v = 128.0 + 128.0 * $sin(2.0 * 3.141592653589793 * i / N);
            r = $rtoi(v + 0.5);
            if (v + 0.5 < 0.0) r = 0;
            if (r > 255) r = 255;
            lut[i] = r;
        end
        test_reset();
        test_default();
        test_fixed();
        test_offsets();
        test_div();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
